// File: rtl/datamem_xy.sv
// XY-addressed word memory with byte-strobed writes and a valid/ready read response.
// Optional power-on/command zero-fill sweep is built in when DATAMEM_CLEAR_EN is defined.
module datamem_xy #(
    parameter int unsigned ROW_BITS   = 4,
    parameter int unsigned COL_BITS   = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    Clock,
    input  logic                    Reset_n,
    input  logic                    Clear,
    output logic                    Busy,
    input  logic                    Req_valid,
    output logic                    Req_ready,
    input  logic                    Req_write,
    input  logic [ROW_BITS-1:0]     X_addr,
    input  logic [COL_BITS-1:0]     Y_addr,
    input  logic [DATA_WIDTH/8-1:0] Byte_en,
    input  logic [DATA_WIDTH-1:0]   Data_in,
    output logic                    Rsp_valid,
    input  logic                    Rsp_ready,
    output logic [DATA_WIDTH-1:0]   Data_out
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned AW    = ROW_BITS + COL_BITS;
    localparam int unsigned Depth = 2 ** AW;

    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [AW-1:0]         req_addr;
    logic                  rsp_free;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  busy;
    logic                  clr_we;
    logic [AW-1:0]         clr_addr;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Row-major linear address, same layout the sweep counter walks.
    assign req_addr  = {X_addr, Y_addr};
    assign rsp_free  = !rsp_valid_q || Rsp_ready;
    assign wr_accept = Req_valid && Req_ready && Req_write;
    assign rd_accept = Req_valid && Req_ready && !Req_write;

`ifdef DATAMEM_CLEAR_EN
    typedef enum logic {StIdle, StClear} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] sweep_q, sweep_d;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StClear;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        unique case (state_q)
            StIdle: begin
                if (Clear) begin
                    state_d = StClear;
                    sweep_d = '0;
                end
            end
            StClear: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == '1) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_comb begin
        busy     = (state_q == StClear);
        clr_we   = busy;
        clr_addr = sweep_q;
    end

    // Clear steals the cycle even in IDLE so a simultaneous request is refused.
    assign Req_ready = !busy && !Clear && rsp_free;
`else
    logic unused_clear;

    assign unused_clear = Clear;
    assign busy         = 1'b0;
    assign clr_we       = 1'b0;
    assign clr_addr     = '0;
    assign Req_ready    = rsp_free;
`endif

    assign Busy = busy;

    always_ff @(posedge Clock) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_accept) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (Byte_en[k]) begin
                    mem_q[req_addr][8*k +: 8] <= Data_in[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        data_d      = data_q;
        if (rd_accept) begin
            rsp_valid_d = 1'b1;
            data_d      = mem_q[req_addr];
        end else if (rsp_valid_q && Rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rsp_valid_q <= 1'b0;
            data_q      <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            data_q      <= data_d;
        end
    end

    assign Rsp_valid = rsp_valid_q;
    assign Data_out  = data_q;

endmodule

// File: tb/tb_datamem_xy.sv
// Directed bench for datamem_xy; the zero-fill scenarios run only when DATAMEM_CLEAR_EN is defined.
module tb_datamem_xy;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Clear;
    logic        Busy;
    logic        Req_valid;
    logic        Req_ready;
    logic        Req_write;
    logic [3:0]  X_addr;
    logic [3:0]  Y_addr;
    logic [3:0]  Byte_en;
    logic [31:0] Data_in;
    logic        Rsp_valid;
    logic        Rsp_ready;
    logic [31:0] Data_out;

    int vectors = 0;
    int errors  = 0;

    datamem_xy dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Clear     (Clear),
        .Busy      (Busy),
        .Req_valid (Req_valid),
        .Req_ready (Req_ready),
        .Req_write (Req_write),
        .X_addr    (X_addr),
        .Y_addr    (Y_addr),
        .Byte_en   (Byte_en),
        .Data_in   (Data_in),
        .Rsp_valid (Rsp_valid),
        .Rsp_ready (Rsp_ready),
        .Data_out  (Data_out)
    );

    always #5 Clock = ~Clock;

    // Drivers: called #1 after a rising edge, return #1 after the accepting edge.
    task automatic do_write(input logic [3:0] x, input logic [3:0] y, input logic [3:0] be,
                            input logic [31:0] d);
        Req_valid = 1'b1; Req_write = 1'b1; X_addr = x; Y_addr = y; Byte_en = be; Data_in = d;
        @(posedge Clock); #1;
        Req_valid = 1'b0; Req_write = 1'b0;
    endtask

    task automatic start_read(input logic [3:0] x, input logic [3:0] y);
        Req_valid = 1'b1; Req_write = 1'b0; X_addr = x; Y_addr = y;
        @(posedge Clock); #1;
        Req_valid = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        Reset_n = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        vectors++;
        if (Rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_valid: got %b expected 0", Rsp_valid);
        end
        vectors++;
        if (Data_out !== 32'h0) begin
            errors++; $display("FAIL reset_data_out: got %h expected 00000000", Data_out);
        end
        Reset_n = 1'b1;
`ifdef DATAMEM_CLEAR_EN
        vectors++;
        if (Busy !== 1'b1) begin
            errors++; $display("FAIL reset_busy: got %b expected 1", Busy);
        end
        n = 0;
        while (Busy === 1'b1 && n < 400) begin
            @(posedge Clock); #1; n++;
        end
        vectors++;
        if (n != 256) begin
            errors++; $display("FAIL reset_sweep_len: got %0d cycles expected 256", n);
        end
        Rsp_ready = 1'b1;
        start_read(4'd15, 4'd15);
        vectors++;
        if (Rsp_valid !== 1'b1 || Data_out !== 32'h0) begin
            errors++;
            $display("FAIL read_15_15: got valid=%b data=%h expected valid=1 data=00000000",
                     Rsp_valid, Data_out);
        end
        @(posedge Clock); #1;
`else
        n = 0;
        vectors++;
        if (Busy !== 1'b0 || Req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b ready=%b expected busy=0 ready=1",
                     Busy, Req_ready);
        end
`endif
    endtask

    task automatic test_byte_en;
        Rsp_ready = 1'b1;
        do_write(4'd3, 4'd5, 4'b1111, 32'hDEADBEEF);
        do_write(4'd3, 4'd5, 4'b0101, 32'h11223344);
        do_write(4'd3, 4'd5, 4'b0000, 32'hFFFFFFFF);
        vectors++;
        if (Rsp_valid !== 1'b0) begin
            errors++; $display("FAIL write_no_rsp: got %b expected 0", Rsp_valid);
        end
        start_read(4'd3, 4'd5);
        vectors++;
        if (Rsp_valid !== 1'b1 || Data_out !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL byte_en_merge: got valid=%b data=%h expected valid=1 data=de22be44",
                     Rsp_valid, Data_out);
        end
        @(posedge Clock); #1;
        vectors++;
        if (Rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rsp_drop: got %b expected 0", Rsp_valid);
        end
    endtask

    task automatic test_wr_then_rd;
        do_write(4'd7, 4'd9, 4'b1111, 32'hCAFEF00D);
        start_read(4'd7, 4'd9);
        vectors++;
        if (Data_out !== 32'hCAFEF00D) begin
            errors++; $display("FAIL wr_then_rd: got %h expected cafef00d", Data_out);
        end
        @(posedge Clock); #1;
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_data [4];
        exp_data[1] = 32'h0101_0101;
        exp_data[2] = 32'h0202_0202;
        exp_data[3] = 32'h0303_0303;
        for (int i = 1; i < 4; i++) do_write(4'd0, 4'(i), 4'b1111, exp_data[i]);
        Rsp_ready = 1'b1;
        Req_valid = 1'b1; Req_write = 1'b0; X_addr = 4'd0; Y_addr = 4'd1;
        for (int i = 1; i < 4; i++) begin
            @(posedge Clock); #1;
            vectors++;
            if (Rsp_valid !== 1'b1 || Data_out !== exp_data[i]) begin
                errors++;
                $display("FAIL b2b_read_%0d: got valid=%b data=%h expected valid=1 data=%h",
                         i, Rsp_valid, Data_out, exp_data[i]);
            end
            if (i < 3) Y_addr = 4'(i + 1);
            else Req_valid = 1'b0;
        end
        @(posedge Clock); #1;
        vectors++;
        if (Rsp_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drop: got %b expected 0", Rsp_valid);
        end
    endtask

    task automatic test_backpressure;
        do_write(4'd2, 4'd2, 4'b1111, 32'hA5A5A5A5);
        Rsp_ready = 1'b0;
        start_read(4'd2, 4'd2);
        // A competing read of [0][1] waits behind the stalled response.
        Req_valid = 1'b1; X_addr = 4'd0; Y_addr = 4'd1;
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (Rsp_valid !== 1'b1 || Data_out !== 32'hA5A5A5A5 || Req_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle_%0d: got valid=%b data=%h ready=%b expected 1/a5a5a5a5/0",
                         c, Rsp_valid, Data_out, Req_ready);
            end
            @(posedge Clock); #1;
        end
        Rsp_ready = 1'b1;
        #1;
        vectors++;
        if (Req_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release_ready: got %b expected 1", Req_ready);
        end
        @(posedge Clock); #1;
        Req_valid = 1'b0;
        vectors++;
        if (Rsp_valid !== 1'b1 || Data_out !== 32'h0101_0101) begin
            errors++;
            $display("FAIL stall_next_read: got valid=%b data=%h expected valid=1 data=01010101",
                     Rsp_valid, Data_out);
        end
        @(posedge Clock); #1;
    endtask

`ifdef DATAMEM_CLEAR_EN
    task automatic test_clear;
        int n;
        do_write(4'd1, 4'd1, 4'b1111, 32'h0000_0077);
        Clear = 1'b1;
        Req_valid = 1'b1; Req_write = 1'b1; X_addr = 4'd1; Y_addr = 4'd1;
        Byte_en = 4'b1111; Data_in = 32'h5;
        #1;
        vectors++;
        if (Req_ready !== 1'b0) begin
            errors++; $display("FAIL clear_blocks_req: got ready=%b expected 0", Req_ready);
        end
        @(posedge Clock); #1;
        Clear = 1'b0; Req_valid = 1'b0; Req_write = 1'b0;
        n = 0;
        // Clear re-pulsed mid-sweep must not restart it.
        while (Busy === 1'b1 && n < 400) begin
            Clear = (n == 50);
            @(posedge Clock); #1; n++;
        end
        Clear = 1'b0;
        vectors++;
        if (n != 256) begin
            errors++; $display("FAIL clear_sweep_len: got %0d cycles expected 256", n);
        end
        start_read(4'd1, 4'd1);
        vectors++;
        if (Rsp_valid !== 1'b1 || Data_out !== 32'h0) begin
            errors++;
            $display("FAIL clear_zeroed: got valid=%b data=%h expected valid=1 data=00000000",
                     Rsp_valid, Data_out);
        end
        @(posedge Clock); #1;
    endtask

    task automatic test_reset_mid_sweep;
        int n;
        Clear = 1'b1;
        @(posedge Clock); #1;
        Clear = 1'b0;
        repeat (100) @(posedge Clock);
        #1;
        vectors++;
        if (Busy !== 1'b1) begin
            errors++; $display("FAIL mid_sweep_busy: got %b expected 1", Busy);
        end
        Reset_n = 1'b0;
        #1;
        vectors++;
        if (Busy !== 1'b1 || Rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_sweep_reset: got busy=%b valid=%b expected busy=1 valid=0",
                     Busy, Rsp_valid);
        end
        @(posedge Clock); #1;
        Reset_n = 1'b1;
        n = 0;
        while (Busy === 1'b1 && n < 400) begin
            @(posedge Clock); #1; n++;
        end
        vectors++;
        if (n != 256) begin
            errors++; $display("FAIL restart_sweep_len: got %0d cycles expected 256", n);
        end
    endtask
`endif

    initial begin
        Reset_n = 1'b0; Clear = 1'b0; Req_valid = 1'b0; Req_write = 1'b0;
        X_addr = '0; Y_addr = '0; Byte_en = '0; Data_in = '0; Rsp_ready = 1'b1;
        #1;
        test_reset();
        test_byte_en();
        test_wr_then_rd();
        test_back_to_back();
        test_backpressure();
`ifdef DATAMEM_CLEAR_EN
        test_clear();
        test_reset_mid_sweep();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/datamem_xy.md
DATAMEM_XY -- requirements
Module: datamem_xy

Interface
REQ-001 Parameter ROW_BITS, default 4: X (row) address width; 2^ROW_BITS rows.
REQ-002 Parameter COL_BITS, default 4: Y (column) address width; 2^COL_BITS columns.
REQ-003 Parameter DATA_WIDTH, default 32: word width; SHALL be a multiple of 8; NB = DATA_WIDTH/8.
REQ-004 Clock  in  1  rising-edge clock; the only clock.
REQ-005 Reset_n  in  1  asynchronous, active-low reset.
REQ-006 Clear  in  1  request zero-fill of the whole array.
REQ-007 Busy  out  1  high while a zero-fill is in progress.
REQ-008 Req_valid  in  1  request present.
REQ-009 Req_ready  out  1  request can be accepted this cycle.
REQ-010 Req_write  in  1  1 = write, 0 = read.
REQ-011 X_addr  in  ROW_BITS  row address.
REQ-012 Y_addr  in  COL_BITS  column address.
REQ-013 Byte_en  in  NB  per-byte write strobe; bit k covers Data_in[8k+7:8k].
REQ-014 Data_in  in  DATA_WIDTH  write data.
REQ-015 Rsp_valid  out  1  read data valid.
REQ-016 Rsp_ready  in  1  downstream accepts read data.
REQ-017 Data_out  out  DATA_WIDTH  read data.

Function
REQ-018 Request accepted on a rising edge where Req_valid && Req_ready.
REQ-019 Req_ready = !Busy && !Clear && (!Rsp_valid || Rsp_ready); combinational, no dependence on Req_valid.
REQ-020 Accepted write updates entry [X_addr][Y_addr] bytes with Byte_en=1 only; other bytes are unchanged; Byte_en=0 leaves the entry untouched. Writes produce no response.
REQ-021 Accepted read in cycle N: Rsp_valid=1 and Data_out=entry contents from cycle N+1.
REQ-022 Data_out and Rsp_valid are held stable while Rsp_valid && !Rsp_ready.
REQ-023 Rsp_valid clears on the edge where Rsp_valid && Rsp_ready unless a new read is accepted on that edge; back-to-back reads sustain one response per cycle.
REQ-024 A read accepted the cycle after a write to the same address returns the written data.
REQ-025 State machine: CLEAR (Busy=1) and IDLE (Busy=0).
REQ-026 CLEAR: one entry zeroed per cycle, row-major from [0][0] to [max][max] via an internal ROW_BITS+COL_BITS counter. CLEAR exits to IDLE on the edge that writes the last entry, taking 2^(ROW_BITS+COL_BITS) cycles.
REQ-027 IDLE -> CLEAR on any edge with Clear=1; Clear takes priority over a simultaneous Req_valid, which is not accepted. Clear is ignored while in CLEAR; the sweep is not restarted.
REQ-028 A response pending at CLEAR entry keeps its captured data and follows REQ-022/023 during the sweep.
REQ-029 Data_out is undefined (don't-care) when Rsp_valid=0.

Reset
REQ-030 Reset_n low: Rsp_valid=0, Data_out=0, the sweep counter=0, and the state is CLEAR (Busy=1) asynchronously.
REQ-031 Array contents are not reset directly; only the sweep zeroes them.
REQ-032 Reset asserted mid-sweep or mid-response aborts the operation; the sweep restarts from [0][0] after release.

Configuration
REQ-033 Macro DATAMEM_CLEAR_EN. When defined, the Clear/Busy behaviour follows REQ-025..028 and REQ-030.
REQ-034 When DATAMEM_CLEAR_EN is undefined:
- no state machine or sweep counter;
- Busy is tied 0 and Clear is ignored;
- the post-reset state is IDLE and Req_ready is governed only by the response term;
- array contents after reset are undefined.

Verification
REQ-035 Reset release with DATAMEM_CLEAR_EN (defaults) -> Busy=1 for exactly 256 cycles, then 0; a read of [15][15] returns 0x00000000.
REQ-036 Write [3][5]=0xDEADBEEF with Byte_en=1111, then write 0x11223344 with Byte_en=0101, then read [3][5] -> 0xDE22BE44 one cycle after acceptance.
REQ-037 Reads of [0][1],[0][2],[0][3] on consecutive cycles with Rsp_ready=1 -> three consecutive Rsp_valid cycles with matching data.
REQ-038 Read [2][2]=0xA5A5A5A5 with Rsp_ready=0 for 4 cycles -> Req_ready=0, Rsp_valid and Data_out held 4 cycles, a new Req_valid is not accepted until the handshake completes.
REQ-039 Clear and Req_valid (write [1][1]=0x5) asserted together in IDLE -> write not accepted, Busy=1 for 256 cycles, [1][1] reads 0.
REQ-040 Reset_n pulsed low at sweep cycle 100 -> Busy stays 1, the sweep restarts, and Busy drops 256 cycles after release.
